// File: rtl/cordic_pkg.sv
// Shared constants, angle table and state encoding for the iterative CORDIC cosine engine.
// All fixed-point values are unsigned Q1.20 unless noted.
package cordic_pkg;

    localparam int FRACS     = 20;
    localparam int INTS      = 1;
    localparam int WIDTH     = INTS + FRACS;
    localparam int GUARD     = 2;
    localparam int IW        = WIDTH + GUARD;
    localparam int ITERS_MAX = 20;

    localparam logic [WIDTH-1:0] K_SCALED = 21'd636751;
    localparam logic [WIDTH-1:0] HALF_PI  = 21'd1647099;
    localparam logic [WIDTH-1:0] ONE      = 21'd1048576;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    // round(atan(2^-i) * 2^20), sign-extended to the internal width
    function automatic logic signed [IW-1:0] atan_lut(input logic [4:0] idx);
        logic signed [IW-1:0] val;
        case (idx)
            5'd0:    val = 23'sd823550;
            5'd1:    val = 23'sd486170;
            5'd2:    val = 23'sd256879;
            5'd3:    val = 23'sd130396;
            5'd4:    val = 23'sd65451;
            5'd5:    val = 23'sd32757;
            5'd6:    val = 23'sd16383;
            5'd7:    val = 23'sd8192;
            5'd8:    val = 23'sd4096;
            5'd9:    val = 23'sd2048;
            5'd10:   val = 23'sd1024;
            5'd11:   val = 23'sd512;
            5'd12:   val = 23'sd256;
            5'd13:   val = 23'sd128;
            5'd14:   val = 23'sd64;
            5'd15:   val = 23'sd32;
            5'd16:   val = 23'sd16;
            5'd17:   val = 23'sd8;
            5'd18:   val = 23'sd4;
            5'd19:   val = 23'sd2;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_microrotation.sv
// One rotation-mode CORDIC step: rotates (x, y) toward the residual angle z by +/-atan(2^-i).
// Purely combinational; shifts are arithmetic and truncate toward minus infinity.
module cordic_microrotation
    import cordic_pkg::*;
(
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [IW-1:0] z_i,
    input  logic        [4:0]    iter_i,
    input  logic signed [IW-1:0] atan_i,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic signed [IW-1:0] z_o
);

    logic                 d;
    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    assign d    = ~z_i[IW-1];
    assign x_sh = x_i >>> iter_i;
    assign y_sh = y_i >>> iter_i;

    assign x_o = d ? (x_i - y_sh)   : (x_i + y_sh);
    assign y_o = d ? (y_i + x_sh)   : (y_i - x_sh);
    assign z_o = d ? (z_i - atan_i) : (z_i + atan_i);

endmodule

// File: rtl/cordic_cos_iter.sv
// Iterative CORDIC cosine: accepts a Q1.20 angle, runs ITERS micro-rotations, and holds the
// clamped Q1.20 cosine until the consumer takes it.
module cordic_cos_iter
    import cordic_pkg::*;
#(
    parameter int ITERS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] angle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] cos_out,
    output logic             out_range
);

    state_t               state_q, state_d;
    logic signed [IW-1:0] x_q, x_d;
    logic signed [IW-1:0] y_q, y_d;
    logic signed [IW-1:0] z_q, z_d;
    logic        [4:0]    iter_q, iter_d;
    logic                 range_q, range_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic        [WIDTH-1:0] cos_q, cos_d;
    logic                 out_range_q, out_range_d;

    logic signed [IW-1:0] mr_x, mr_y, mr_z;
    logic        [WIDTH-1:0] clamp_cos;

    cordic_microrotation u_microrotation (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .iter_i (iter_q),
        .atan_i (atan_lut(iter_q)),
        .x_o    (mr_x),
        .y_o    (mr_y),
        .z_o    (mr_z)
    );

    // Negative x means the angle overshot pi/2; bit WIDTH set means x >= 2.0 (saturate).
    always_comb begin
        if (mr_x[IW-1] || range_q) begin
            clamp_cos = '0;
        end else if (mr_x[WIDTH]) begin
            clamp_cos = '1;
        end else begin
            clamp_cos = mr_x[WIDTH-1:0];
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        range_d     = range_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cos_d       = cos_q;
        out_range_d = out_range_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    x_d        = {2'b00, K_SCALED};
                    y_d        = '0;
                    z_d        = {2'b00, angle_in};
                    range_d    = (angle_in > HALF_PI);
                    iter_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = ROTATE;
                end
            end
            ROTATE: begin
                x_d    = mr_x;
                y_d    = mr_y;
                z_d    = mr_z;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(ITERS - 1)) begin
                    cos_d       = clamp_cos;
                    out_range_d = range_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            range_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cos_q       <= '0;
            out_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            range_q     <= range_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cos_q       <= cos_d;
            out_range_q <= out_range_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign cos_out   = cos_q;
    assign out_range = out_range_q;

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Directed bench for cordic_cos_iter: reset, latency, back-to-back, backpressure, range clamp
// and mid-operation reset, with hand-computed expected cosines.
module tb_cordic_cos_iter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] angle_in;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] cos_out;
    logic        out_range;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_cos_iter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .out_range (out_range)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Latency counts the handshake edge as edge 1, so out_valid appears on edge ITERS+1 = 17.
    task automatic run_angle(input logic [20:0] a, input logic ordy,
                             output int c, output int r, output int lat);
        int n;
        lat = -1;
        c   = 0;
        r   = 0;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 0, 1, 0);
            return;
        end
        angle_in  = a;
        in_valid  = 1'b1;
        out_ready = ordy;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) begin
            check("out_valid_wait", 0, 1, 0);
            lat = -1;
            return;
        end
        c = cos_out;
        r = out_range;
        if (ordy) begin
            @(posedge clk);
            @(negedge clk);
            check("consumed_valid_low", out_valid, 0, 0);
            check("in_ready_after_hs", in_ready, 1, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, lat, unstable, ghost, held;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        angle_in  = '0;

        // Reset held for 3 cycles
        @(negedge clk);
        check("rst_in_ready", in_ready, 0, 0);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_cos", cos_out, 0, 0);
        check("rst_range", out_range, 0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 check("in_ready_pre_edge", in_ready, 0, 0);
        @(negedge clk);
        check("in_ready_post_edge", in_ready, 1, 0);

        // angle 0 -> ~1.0
        run_angle(21'd0, 1'b1, c, r, lat);
        check("lat_zero", lat, 17, 0);
        check("cos_zero", c, 1048576, 32);
        check("range_zero", r, 0, 0);

        // Back-to-back 0.5 then 1.0
        run_angle(21'd524288, 1'b1, c, r, lat);
        check("lat_half", lat, 17, 0);
        check("cos_half", c, 920212, 32);
        run_angle(21'd1048576, 1'b1, c, r, lat);
        check("lat_one", lat, 17, 0);
        check("cos_one", c, 566548, 32);
        check("range_one", r, 0, 0);

        // Backpressure: hold result for 10 cycles while in_valid pulses
        run_angle(21'd524288, 1'b0, c, r, lat);
        check("cos_bp", c, 920212, 32);
        held     = c;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid = k[0];
            angle_in = 21'd1835008;
            @(negedge clk);
            if (out_valid !== 1'b1 || cos_out !== 21'(held)) unstable++;
            if (in_ready !== 1'b0) unstable++;
        end
        in_valid = 1'b0;
        check("stall_stable", unstable, 0, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_valid", out_valid, 0, 0);
        check("bp_released_ready", in_ready, 1, 0);
        ghost = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check("no_ghost_result", ghost, 0, 0);

        // Range clamp and boundaries around pi/2
        run_angle(21'd1835008, 1'b1, c, r, lat);
        check("cos_over", c, 0, 0);
        check("range_over", r, 1, 0);
        run_angle(21'd0, 1'b1, c, r, lat);
        check("range_cleared", r, 0, 0);
        check("cos_after_range", c, 1048576, 32);
        run_angle(21'd1647099, 1'b1, c, r, lat);
        check("cos_halfpi", c, 0, 32);
        check("range_halfpi", r, 0, 0);
        run_angle(21'd1647100, 1'b1, c, r, lat);
        check("cos_halfpi_p1", c, 0, 0);
        check("range_halfpi_p1", r, 1, 0);

        // Mid-operation reset: accept 1.0 then reset 5 cycles later
        @(negedge clk);
        angle_in = 21'd1048576;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0, 0);
        check("midrst_valid", out_valid, 0, 0);
        check("midrst_cos", cos_out, 0, 0);
        ghost = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check("midrst_no_result", ghost, 0, 0);
        run_angle(21'd0, 1'b1, c, r, lat);
        check("midrst_lat", lat, 17, 0);
        check("midrst_cos_zero", c, 1048576, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
